// File: rtl/iob_native_arbiter_pkg.sv
// Shared definitions for the IOb native-bus arbiter: FSM state encoding
// and the index-width helper used to size grant_id and the rr pointer.
package iob_native_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Width of an index into n requesters; a single requester still needs one bit.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iob_rr_picker.sv
// Combinational round-robin picker: returns the first requesting index at or
// after the pointer, wrapping modulo N, plus a flag that anyone is requesting.
module iob_rr_picker
    import iob_native_arbiter_pkg::*;
#(
    parameter int N     = 2,
    parameter int GID_W = 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [GID_W-1:0] i_ptr,
    output logic [GID_W-1:0] o_winner,
    output logic             o_anyReq
);

    logic w_found;
    int   w_idx;

    assign o_anyReq = |i_req;

    // Scan the requests starting at the pointer; the first hit wins.
    always_comb begin
        o_winner = '0;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = (int'(i_ptr) + k) % N;
            if (!w_found && i_req[w_idx]) begin
                w_found  = 1'b1;
                o_winner = GID_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/iob_native_arbiter.sv
// Round-robin arbiter sharing one IOb native-bus slave between N_MASTERS
// requesters, one outstanding transaction at a time, with a per-transaction
// watchdog that completes a hung access with ERR_RDATA and a sticky error.
module iob_native_arbiter
    import iob_native_arbiter_pkg::*;
#(
    parameter int              N_MASTERS = 2,
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 32,
    parameter int              TIMEOUT_W = 10,
    parameter logic [DATA_W-1:0] ERR_RDATA = 32'hDEADBEEF,
    localparam int             STRB_W    = DATA_W / 8,
    localparam int             GID_W     = idxWidth(N_MASTERS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_MASTERS-1:0]          m_valid,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
    input  logic [N_MASTERS*STRB_W-1:0]   m_wstrb,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [N_MASTERS-1:0]          m_ready,
    output logic                          s_valid,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [STRB_W-1:0]             s_wstrb,
    input  logic [DATA_W-1:0]             s_rdata,
    input  logic                          s_ready,
    output logic [GID_W-1:0]              grant_id,
    output logic                          timeout_err,
    input  logic                          timeout_clr
);

    arb_state_t          r_state;
    arb_state_t          w_stateNext;
    logic [GID_W-1:0]    r_grantId;
    logic [GID_W-1:0]    r_ptr;
    logic [GID_W-1:0]    w_ptrNext;
    logic [TIMEOUT_W-1:0] r_wdog;
    logic                r_timeoutErr;
    logic [ADDR_W-1:0]   r_sAddr;
    logic [DATA_W-1:0]   r_sWdata;
    logic [STRB_W-1:0]   r_sWstrb;

    logic [GID_W-1:0]    w_winner;
    logic                w_anyReq;
    logic                w_grant;
    logic                w_timeout;
    logic                w_done;
    logic                w_errDone;
    logic [N_MASTERS-1:0] w_mReady;

    iob_rr_picker #(
        .N     (N_MASTERS),
        .GID_W (GID_W)
    ) u_picker (
        .i_req    (m_valid),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_anyReq (w_anyReq)
    );

    // A grant happens only from IDLE; completion is slave ready or watchdog
    // expiry, and slave ready takes precedence so a late response is not an error.
    assign w_grant   = (r_state == ST_IDLE) && w_anyReq;
    assign w_timeout = (r_wdog == {TIMEOUT_W{1'b1}});
    assign w_done    = (r_state == ST_BUSY) && (s_ready || w_timeout);
    assign w_errDone = (r_state == ST_BUSY) && !s_ready && w_timeout;
    assign w_ptrNext = (r_grantId == GID_W'(N_MASTERS - 1)) ? '0 : r_grantId + 1'b1;

    // s_valid follows the state directly so an async reset drops it at once.
    assign s_valid     = (r_state == ST_BUSY);
    assign s_addr      = r_sAddr;
    assign s_wdata     = r_sWdata;
    assign s_wstrb     = r_sWstrb;
    assign grant_id    = r_grantId;
    assign timeout_err = r_timeoutErr;
    assign m_rdata     = w_errDone ? ERR_RDATA : s_rdata;
    assign m_ready     = w_mReady;

    // One-hot completion pulse towards the granted master.
    always_comb begin
        w_mReady = '0;
        if (w_done) begin
            w_mReady[r_grantId] = 1'b1;
        end
    end

    // Next-state logic: IDLE grants when anyone asks, BUSY ends on completion.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE: if (w_anyReq) w_stateNext = ST_BUSY;
            ST_BUSY: if (w_done)   w_stateNext = ST_IDLE;
            default: w_stateNext = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Latch the winner's request on grant; advance the rr pointer on completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grantId <= '0;
            r_ptr     <= '0;
            r_sAddr   <= '0;
            r_sWdata  <= '0;
            r_sWstrb  <= '0;
        end else if (w_grant) begin
            r_grantId <= w_winner;
            r_sAddr   <= m_addr[w_winner*ADDR_W +: ADDR_W];
            r_sWdata  <= m_wdata[w_winner*DATA_W +: DATA_W];
            r_sWstrb  <= m_wstrb[w_winner*STRB_W +: STRB_W];
        end else if (w_done) begin
            r_ptr     <= w_ptrNext;
        end
    end

    // Watchdog counts BUSY cycles; it restarts at every grant and completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wdog <= '0;
        end else if (w_grant || w_done) begin
            r_wdog <= '0;
        end else if (r_state == ST_BUSY) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    // Sticky error flag; a fresh timeout beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timeoutErr <= 1'b0;
        end else if (w_errDone) begin
            r_timeoutErr <= 1'b1;
        end else if (timeout_clr) begin
            r_timeoutErr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_iob_native_arbiter.sv
// Scoreboard bench for iob_native_arbiter: stimulus pushes the expected
// completion into a queue, a negedge monitor pops and compares on m_ready.
module tb_iob_native_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    typedef struct {
        logic [N-1:0]  ready;
        logic [DW-1:0] rdata;
        logic [0:0]    gid;
        int            cycle;
    } exp_t;

    logic            clk;
    logic            reset;
    logic [N-1:0]    m_valid;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [N*SW-1:0] m_wstrb;
    logic [DW-1:0]   m_rdata;
    logic [N-1:0]    m_ready;
    logic            s_valid;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic [SW-1:0]   s_wstrb;
    logic [DW-1:0]   s_rdata;
    logic            s_ready;
    logic [0:0]      grant_id;
    logic            timeout_err;
    logic            timeout_clr;

    exp_t expQ[$];
    int   testsRun  = 0;
    int   failures  = 0;
    int   cycleCount = 0;
    int   g;

    iob_native_arbiter #(
        .N_MASTERS (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .TIMEOUT_W (4),
        .ERR_RDATA (32'hDEADBEEF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m_valid     (m_valid),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_wstrb     (m_wstrb),
        .m_rdata     (m_rdata),
        .m_ready     (m_ready),
        .s_valid     (s_valid),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_wstrb     (s_wstrb),
        .s_rdata     (s_rdata),
        .s_ready     (s_ready),
        .grant_id    (grant_id),
        .timeout_err (timeout_err),
        .timeout_clr (timeout_clr)
    );

    // 10-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to check watchdog completion timing.
    always @(posedge clk) begin
        cycleCount <= cycleCount + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int m, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                 input logic [SW-1:0] wstrb);
        m_addr[m*AW +: AW]  = addr;
        m_wdata[m*DW +: DW] = wdata;
        m_wstrb[m*SW +: SW] = wstrb;
    endtask

    task automatic pushExp(input logic [N-1:0] rdy, input logic [DW-1:0] rd, input logic [0:0] gid, input int cyc);
        exp_t e;
        e.ready = rdy;
        e.rdata = rd;
        e.gid   = gid;
        e.cycle = cyc;
        expQ.push_back(e);
    endtask

    // Monitor: every m_ready pulse must match the oldest expected completion.
    always @(negedge clk) begin
        exp_t e;
        if (m_ready != '0) begin
            if (expQ.size() == 0) begin
                testsRun++;
                failures++;
                $display("[TB] FAIL unexpected_m_ready: got %b, expected none", m_ready);
            end else begin
                e = expQ.pop_front();
                checkOutput("m_ready", 32'(m_ready), 32'(e.ready));
                checkOutput("m_rdata", m_rdata, e.rdata);
                checkOutput("grant_id_at_done", 32'(grant_id), 32'(e.gid));
                if (e.cycle >= 0) checkOutput("done_cycle", 32'(cycleCount), 32'(e.cycle));
            end
        end
    end

    // Hard stop in case anything stalls.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "[TB] stalled");
    end

    initial begin
        reset = 1'b0; m_valid = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
        s_rdata = '0; s_ready = 1'b0; timeout_clr = 1'b0;

        // Reset state
        tick(); tick();
        checkOutput("rst_s_valid", 32'(s_valid), 32'd0);
        checkOutput("rst_s_addr", s_addr, 32'd0);
        checkOutput("rst_grant_id", 32'(grant_id), 32'd0);
        checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
        checkOutput("rst_m_ready", 32'(m_ready), 32'd0);
        reset = 1'b1;
        tick();

        // Single read from master 0, slave responds in the third BUSY cycle
        applyStimulus(0, 32'h100, 32'h0, 4'b0000);
        m_valid = 2'b01;
        tick();
        checkOutput("rd_s_valid", 32'(s_valid), 32'd1);
        checkOutput("rd_s_addr", s_addr, 32'h100);
        checkOutput("rd_grant_id", 32'(grant_id), 32'd0);
        tick(); tick();
        s_ready = 1'b1; s_rdata = 32'h12345678;
        pushExp(2'b01, 32'h12345678, 1'b0, -1);
        tick();
        m_valid = 2'b00; s_ready = 1'b0;
        checkOutput("rd_idle_s_valid", 32'(s_valid), 32'd0);
        tick();

        // Contention: pointer sits at 1 after master 0 was served
        applyStimulus(0, 32'h1000, 32'h0, 4'b0000);
        applyStimulus(1, 32'h2000, 32'h0, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            pushExp((i % 2 == 0) ? 2'b10 : 2'b01, 32'hC0DE0001, (i % 2 == 0) ? 1'b1 : 1'b0, -1);
        end
        s_rdata = 32'hC0DE0001; s_ready = 1'b1;
        m_valid = 2'b11;
        repeat (8) tick();
        m_valid = 2'b00; s_ready = 1'b0;
        checkOutput("cont_all_served", 32'(expQ.size()), 32'd0);
        checkOutput("cont_last_grant", 32'(grant_id), 32'd0);
        tick();

        // Write pass-through from master 1
        applyStimulus(0, 32'hFFFF0000, 32'h11111111, 4'b1111);
        applyStimulus(1, 32'h20, 32'hA5A5A5A5, 4'b0011);
        m_valid = 2'b10;
        tick();
        checkOutput("wr_s_addr", s_addr, 32'h20);
        checkOutput("wr_s_wdata", s_wdata, 32'hA5A5A5A5);
        checkOutput("wr_s_wstrb", 32'(s_wstrb), 32'h3);
        checkOutput("wr_grant_id", 32'(grant_id), 32'd1);
        applyStimulus(0, 32'hEEEE0000, 32'h22222222, 4'b0101);
        tick();
        checkOutput("wr_stable_addr", s_addr, 32'h20);
        checkOutput("wr_stable_wdata", s_wdata, 32'hA5A5A5A5);
        s_ready = 1'b1; s_rdata = 32'h13572468;
        pushExp(2'b10, 32'h13572468, 1'b1, -1);
        tick();
        m_valid = 2'b00; s_ready = 1'b0;
        tick();

        // Timeout: watchdog reaches 15 after 15 BUSY edges past the grant
        applyStimulus(0, 32'h300, 32'h0, 4'b0000);
        m_valid = 2'b01; s_rdata = 32'h11111111;
        tick();
        g = cycleCount;
        checkOutput("to_s_valid", 32'(s_valid), 32'd1);
        pushExp(2'b01, 32'hDEADBEEF, 1'b0, g + 15);
        repeat (15) tick();
        tick();
        m_valid = 2'b00;
        checkOutput("to_err_set", 32'(timeout_err), 32'd1);
        checkOutput("to_s_valid_low", 32'(s_valid), 32'd0);
        tick();
        checkOutput("to_err_sticky", 32'(timeout_err), 32'd1);
        timeout_clr = 1'b1;
        tick();
        timeout_clr = 1'b0;
        checkOutput("to_err_cleared", 32'(timeout_err), 32'd0);

        // s_ready coincides with the watchdog expiry: data passes, no error
        m_valid = 2'b01; s_rdata = 32'h22222222;
        tick();
        g = cycleCount;
        repeat (15) tick();
        s_ready = 1'b1; s_rdata = 32'h0BADF00D;
        pushExp(2'b01, 32'h0BADF00D, 1'b0, g + 15);
        tick();
        m_valid = 2'b00; s_ready = 1'b0;
        checkOutput("coinc_no_err", 32'(timeout_err), 32'd0);
        tick();

        // Reset mid-BUSY: s_valid falls asynchronously, no completion
        applyStimulus(1, 32'h600, 32'h0, 4'b0000);
        m_valid = 2'b10;
        tick();
        checkOutput("rstb_busy", 32'(s_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("rstb_async_s_valid", 32'(s_valid), 32'd0);
        checkOutput("rstb_no_m_ready", 32'(m_ready), 32'd0);
        tick();
        reset = 1'b1;
        applyStimulus(0, 32'h500, 32'h0, 4'b0000);
        m_valid = 2'b11; s_ready = 1'b1; s_rdata = 32'h600D600D;
        pushExp(2'b01, 32'h600D600D, 1'b0, -1);
        tick();
        checkOutput("rstb_grant0", 32'(grant_id), 32'd0);
        checkOutput("rstb_s_addr", s_addr, 32'h500);
        tick();
        m_valid = 2'b00; s_ready = 1'b0;
        tick(); tick();

        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
